// File: rtl/diff_demo_pkg.sv
// Shared configuration and controller state type for the diff core
// feature-map / guard buffer banks.
package diff_demo_pkg;

    localparam int CONF_PE_COL          = 4;
    localparam int CONF_FM_BUF_DEPTH    = 512;
    localparam int CONF_GUARD_BUF_DEPTH = 512;
    localparam int CONF_DATA_W          = 72;

    // Encoded as {active_valid, fill_full}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b10,
        FULL   = 2'b11
    } bank_state_e;

endpackage

// File: rtl/pingpong_bank_ctrl.sv
// Bank-level commit/release controller: tracks which bank is active,
// whether the fill bank is committed, and pulses on every swap.
module pingpong_bank_ctrl
    import diff_demo_pkg::*;
#(
    parameter int PINGPONG = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_commit,
    input  logic i_release,
    output logic o_active_valid,
    output logic o_fill_full,
    output logic o_bank_sel,
    output logic o_swap_pulse,
    output logic o_swap_now
);

    localparam bit PP = (PINGPONG != 0);

    bank_state_e r_state;
    logic        r_bank_sel;
    logic        r_swap_pulse;
    logic        w_swap;

    always_comb begin
        w_swap = 1'b0;
        case (r_state)
            EMPTY:   w_swap = i_commit;
            ACTIVE:  w_swap = i_commit & i_release;
            FULL:    w_swap = i_release;
            default: w_swap = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_bank_sel   <= 1'b0;
            r_swap_pulse <= 1'b0;
        end else begin
            r_swap_pulse <= w_swap;
            if (w_swap) begin
                r_state <= ACTIVE;
                if (PP) begin
                    r_bank_sel <= ~r_bank_sel;
                end
            end else begin
                case (r_state)
                    ACTIVE: begin
                        if (i_release) begin
                            r_state <= EMPTY;
                        end else if (i_commit) begin
                            r_state <= FULL;
                        end
                    end
                    EMPTY, FULL: r_state <= r_state;
                    default:     r_state <= EMPTY;
                endcase
            end
        end
    end

    assign o_active_valid = r_state[1];
    assign o_fill_full    = r_state[0];
    assign o_bank_sel     = r_bank_sel;
    assign o_swap_pulse   = r_swap_pulse;
    assign o_swap_now     = w_swap;

endmodule

// File: rtl/two_port_mem.sv
// Simple two-port memory: one write port, one registered read port.
// No reset on contents or read data.
module two_port_mem #(
    parameter  int DATA_W = 72,
    parameter  int DEPTH  = 512,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fm_pingpong_buf_bank.sv
// Per-column ping-pong feature-map/guard buffer bank with commit/release swap.
// Optional FMBUF_OCCUPANCY_EN adds per-column fill length tracking and active_len.
module fm_pingpong_buf_bank
    import diff_demo_pkg::*;
#(
    parameter  int N_COL    = CONF_PE_COL,
    parameter  int DATA_W   = CONF_DATA_W,
    parameter  int DEPTH    = CONF_FM_BUF_DEPTH,
    parameter  int PINGPONG = 1,
    parameter  int WB_PRIO  = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_COL*AW-1:0]     ld_addr,
    input  logic [N_COL*DATA_W-1:0] ld_din,
    input  logic [N_COL-1:0]        ld_en,
    output logic [N_COL-1:0]        ld_ready,
    input  logic [N_COL*AW-1:0]     wb_addr,
    input  logic [N_COL*DATA_W-1:0] wb_din,
    input  logic [N_COL-1:0]        wb_en,
    output logic [N_COL-1:0]        wb_ready,
    input  logic [N_COL*AW-1:0]     rd_addr,
    input  logic [N_COL-1:0]        rd_en,
    output logic [N_COL*DATA_W-1:0] rd_dout,
    output logic [N_COL-1:0]        rd_valid,
    input  logic                    fill_commit,
    input  logic                    compute_release,
    output logic                    active_valid,
    output logic                    fill_full,
    output logic                    bank_sel,
    output logic                    swap_pulse,
`ifdef FMBUF_OCCUPANCY_EN
    output logic [N_COL*(AW+1)-1:0] active_len,
`endif
    output logic [1:0]              err_sticky
);

    localparam bit PP = (PINGPONG != 0);
    localparam int NB = PP ? 2 : 1;

    logic             w_active_valid;
    logic             w_fill_full;
    logic             w_bank_sel;
    logic             w_swap_pulse;
    logic             w_swap_now;
    logic             w_fill_wr_ok;
    logic             w_fill_bank;
    logic             w_rd_bank;
    logic [N_COL-1:0] w_werr;
    logic [N_COL-1:0] w_rerr;
    logic [1:0]       r_err;

    pingpong_bank_ctrl #(
        .PINGPONG(PINGPONG)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_commit      (fill_commit),
        .i_release     (compute_release),
        .o_active_valid(w_active_valid),
        .o_fill_full   (w_fill_full),
        .o_bank_sel    (w_bank_sel),
        .o_swap_pulse  (w_swap_pulse),
        .o_swap_now    (w_swap_now)
    );

    // Single-bank mode must not write while the PE matrix owns the bank.
    assign w_fill_wr_ok = ~w_fill_full & (PP | ~w_active_valid);
    assign w_fill_bank  = PP ? ~w_bank_sel : 1'b0;
    assign w_rd_bank    = PP ? w_bank_sel : 1'b0;

`ifndef FMBUF_OCCUPANCY_EN
    logic w_unused;
    assign w_unused = w_swap_now;
`endif

    for (genvar j = 0; j < N_COL; j++) begin : g_col
        logic              w_wb_win;
        logic              w_ld_win;
        logic              w_we;
        logic [AW-1:0]     w_waddr;
        logic [DATA_W-1:0] w_wdata;
        logic [AW-1:0]     w_raddr;
        logic              w_len_ok;
        logic              w_rd_ok;
        logic              r_rd_valid;
        logic [DATA_W-1:0] w_q [NB];

        if (WB_PRIO != 0) begin : g_wb_first
            assign wb_ready[j] = w_fill_wr_ok;
            assign ld_ready[j] = w_fill_wr_ok & ~wb_en[j];
        end else begin : g_ld_first
            assign ld_ready[j] = w_fill_wr_ok;
            assign wb_ready[j] = w_fill_wr_ok & ~ld_en[j];
        end

        assign w_wb_win = wb_en[j] & wb_ready[j];
        assign w_ld_win = ld_en[j] & ld_ready[j];
        assign w_we     = w_wb_win | w_ld_win;
        assign w_waddr  = w_wb_win ? wb_addr[j*AW +: AW]
                                   : ld_addr[j*AW +: AW];
        assign w_wdata  = w_wb_win ? wb_din[j*DATA_W +: DATA_W]
                                   : ld_din[j*DATA_W +: DATA_W];
        assign w_raddr  = rd_addr[j*AW +: AW];

`ifdef FMBUF_OCCUPANCY_EN
        localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
        logic [AW:0] r_fill_cnt;
        logic [AW:0] r_len;
        logic [AW:0] w_cnt_nxt;

        always_comb begin
            w_cnt_nxt = r_fill_cnt;
            if (w_we && ({1'b0, w_waddr} >= r_fill_cnt)) begin
                w_cnt_nxt = {1'b0, w_waddr} + ONE;
            end
        end

        // A write landing in the swap cycle belongs to the bank going active.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_fill_cnt <= '0;
                r_len      <= '0;
            end else if (w_swap_now) begin
                r_len      <= w_cnt_nxt;
                r_fill_cnt <= '0;
            end else begin
                r_fill_cnt <= w_cnt_nxt;
            end
        end

        assign w_len_ok = ({1'b0, w_raddr} < r_len);
        assign active_len[j*(AW+1) +: AW+1] = r_len;
`else
        assign w_len_ok = 1'b1;
`endif

        assign w_rd_ok   = rd_en[j] & w_active_valid & w_len_ok;
        assign w_werr[j] = (ld_en[j] | wb_en[j]) & ~w_fill_wr_ok;
        assign w_rerr[j] = rd_en[j] & ~w_rd_ok;

        for (genvar b = 0; b < NB; b++) begin : g_bank
            two_port_mem #(
                .DATA_W(DATA_W),
                .DEPTH (DEPTH)
            ) u_mem (
                .clk    (clk),
                .i_we   (w_we & (w_fill_bank == 1'(b))),
                .i_waddr(w_waddr),
                .i_wdata(w_wdata),
                .i_re   (w_rd_ok & (w_rd_bank == 1'(b))),
                .i_raddr(w_raddr),
                .o_rdata(w_q[b])
            );
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_ok;
            end
        end

        assign rd_valid[j] = r_rd_valid;

        if (NB == 2) begin : g_mux2
            logic r_rd_bank;

            always_ff @(posedge clk) begin
                if (w_rd_ok) begin
                    r_rd_bank <= w_rd_bank;
                end
            end

            assign rd_dout[j*DATA_W +: DATA_W] = r_rd_bank ? w_q[1] : w_q[0];
        end else begin : g_mux1
            assign rd_dout[j*DATA_W +: DATA_W] = w_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 2'b00;
        end else begin
            r_err <= r_err | {|w_rerr, |w_werr};
        end
    end

    assign active_valid = w_active_valid;
    assign fill_full    = w_fill_full;
    assign bank_sel     = w_bank_sel;
    assign swap_pulse   = w_swap_pulse;
    assign err_sticky   = r_err;

endmodule

// File: tb/tb_fm_pingpong_buf_bank.sv
// Bench for fm_pingpong_buf_bank: a ping-pong/write-back-priority instance
// and a single-bank/load-priority instance checked against a reference model.
module tb_fm_pingpong_buf_bank;

    localparam int N     = 4;
    localparam int DW    = 72;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam int PPK [2] = '{1, 0};
    localparam int WBK [2] = '{1, 0};

    logic            clk = 1'b0;
    logic            rst_n [2];
    logic [N*AW-1:0] ld_addr [2];
    logic [N*AW-1:0] wb_addr [2];
    logic [N*AW-1:0] rd_addr [2];
    logic [N*DW-1:0] ld_din [2];
    logic [N*DW-1:0] wb_din [2];
    logic [N*DW-1:0] rd_dout [2];
    logic [N-1:0]    ld_en [2];
    logic [N-1:0]    ld_ready [2];
    logic [N-1:0]    wb_en [2];
    logic [N-1:0]    wb_ready [2];
    logic [N-1:0]    rd_en [2];
    logic [N-1:0]    rd_valid [2];
    logic            fill_commit [2];
    logic            compute_release [2];
    logic            active_valid [2];
    logic            fill_full [2];
    logic            bank_sel [2];
    logic            swap_pulse [2];
    logic [1:0]      err_sticky [2];

    always #5 clk = ~clk;

    fm_pingpong_buf_bank #(
        .N_COL(N), .DATA_W(DW), .DEPTH(DEPTH), .PINGPONG(1), .WB_PRIO(1)
    ) u_pp (
        .clk(clk), .rst_n(rst_n[0]),
        .ld_addr(ld_addr[0]), .ld_din(ld_din[0]), .ld_en(ld_en[0]),
        .ld_ready(ld_ready[0]),
        .wb_addr(wb_addr[0]), .wb_din(wb_din[0]), .wb_en(wb_en[0]),
        .wb_ready(wb_ready[0]),
        .rd_addr(rd_addr[0]), .rd_en(rd_en[0]), .rd_dout(rd_dout[0]),
        .rd_valid(rd_valid[0]),
        .fill_commit(fill_commit[0]), .compute_release(compute_release[0]),
        .active_valid(active_valid[0]), .fill_full(fill_full[0]),
        .bank_sel(bank_sel[0]), .swap_pulse(swap_pulse[0]),
        .err_sticky(err_sticky[0])
    );

    fm_pingpong_buf_bank #(
        .N_COL(N), .DATA_W(DW), .DEPTH(DEPTH), .PINGPONG(0), .WB_PRIO(0)
    ) u_sb (
        .clk(clk), .rst_n(rst_n[1]),
        .ld_addr(ld_addr[1]), .ld_din(ld_din[1]), .ld_en(ld_en[1]),
        .ld_ready(ld_ready[1]),
        .wb_addr(wb_addr[1]), .wb_din(wb_din[1]), .wb_en(wb_en[1]),
        .wb_ready(wb_ready[1]),
        .rd_addr(rd_addr[1]), .rd_en(rd_en[1]), .rd_dout(rd_dout[1]),
        .rd_valid(rd_valid[1]),
        .fill_commit(fill_commit[1]), .compute_release(compute_release[1]),
        .active_valid(active_valid[1]), .fill_full(fill_full[1]),
        .bank_sel(bank_sel[1]), .swap_pulse(swap_pulse[1]),
        .err_sticky(err_sticky[1])
    );

    // Reference model: flags, per-bank word arrays, expected read results.
    bit            m_init [2];
    bit            m_av [2];
    bit            m_ff [2];
    bit            m_sel [2];
    logic [1:0]    m_err [2];
    logic [DW-1:0] mm [2][2][N][DEPTH];
    bit            mk [2][2][N][DEPTH];
    logic [DW-1:0] e_rd [2][N];
    bit            e_rk [2][N];

    int n_chk = 0;
    int n_err = 0;

    function automatic string tag(int k, string s);
        return $sformatf("u%0d_%s", k, s);
    endfunction

    function automatic logic [DW-1:0] rnd72();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    task automatic chk(string t, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            rst_n[k]           = 1'b1;
            ld_en[k]           = '0;
            wb_en[k]           = '0;
            rd_en[k]           = '0;
            fill_commit[k]     = 1'b0;
            compute_release[k] = 1'b0;
        end
    endtask

    task automatic set_ld(int k, int c, int a, logic [DW-1:0] d);
        ld_en[k][c]            = 1'b1;
        ld_addr[k][c*AW +: AW] = AW'(a);
        ld_din[k][c*DW +: DW]  = d;
    endtask

    task automatic set_wb(int k, int c, int a, logic [DW-1:0] d);
        wb_en[k][c]            = 1'b1;
        wb_addr[k][c*AW +: AW] = AW'(a);
        wb_din[k][c*DW +: DW]  = d;
    endtask

    task automatic set_rd(int k, int c, int a);
        rd_en[k][c]            = 1'b1;
        rd_addr[k][c*AW +: AW] = AW'(a);
    endtask

    task automatic step();
        bit           ok [2];
        logic [N-1:0] eld [2];
        logic [N-1:0] ewb [2];
        logic [N-1:0] erv;
        bit           sw;
        int           fb, rb, a;
        #1;
        for (int k = 0; k < 2; k++) begin
            ok[k] = !m_ff[k] && (PPK[k] == 1 || !m_av[k]);
            for (int c = 0; c < N; c++) begin
                if (WBK[k] == 1) begin
                    ewb[k][c] = ok[k];
                    eld[k][c] = ok[k] && !wb_en[k][c];
                end else begin
                    eld[k][c] = ok[k];
                    ewb[k][c] = ok[k] && !ld_en[k][c];
                end
            end
            if (m_init[k]) begin
                chk(tag(k, "ld_ready"), DW'(ld_ready[k]), DW'(eld[k]));
                chk(tag(k, "wb_ready"), DW'(wb_ready[k]), DW'(ewb[k]));
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            erv = '0;
            sw  = 1'b0;
            if (!rst_n[k]) begin
                m_init[k] = 1'b1;
                m_av[k]   = 1'b0;
                m_ff[k]   = 1'b0;
                m_sel[k]  = 1'b0;
                m_err[k]  = 2'b00;
            end else begin
                fb = (PPK[k] == 1) ? int'(!m_sel[k]) : 0;
                rb = (PPK[k] == 1) ? int'(m_sel[k]) : 0;
                for (int c = 0; c < N; c++) begin
                    a = int'(rd_addr[k][c*AW +: AW]);
                    if (rd_en[k][c]) begin
                        if (m_av[k]) begin
                            erv[c]     = 1'b1;
                            e_rd[k][c] = mm[k][rb][c][a];
                            e_rk[k][c] = mk[k][rb][c][a];
                        end else begin
                            m_err[k][1] = 1'b1;
                        end
                    end
                end
                for (int c = 0; c < N; c++) begin
                    if ((ld_en[k][c] || wb_en[k][c]) && !ok[k]) m_err[k][0] = 1'b1;
                    if (wb_en[k][c] && ewb[k][c]) begin
                        a = int'(wb_addr[k][c*AW +: AW]);
                        mm[k][fb][c][a] = wb_din[k][c*DW +: DW];
                        mk[k][fb][c][a] = 1'b1;
                    end else if (ld_en[k][c] && eld[k][c]) begin
                        a = int'(ld_addr[k][c*AW +: AW]);
                        mm[k][fb][c][a] = ld_din[k][c*DW +: DW];
                        mk[k][fb][c][a] = 1'b1;
                    end
                end
                sw = (!m_av[k] && fill_commit[k]) ||
                     (m_av[k] && !m_ff[k] && fill_commit[k] && compute_release[k]) ||
                     (m_ff[k] && compute_release[k]);
                if (sw) begin
                    m_av[k] = 1'b1;
                    m_ff[k] = 1'b0;
                    if (PPK[k] == 1) m_sel[k] = !m_sel[k];
                end else if (m_av[k] && !m_ff[k] && compute_release[k]) begin
                    m_av[k] = 1'b0;
                end else if (m_av[k] && !m_ff[k] && fill_commit[k]) begin
                    m_ff[k] = 1'b1;
                end
            end
            if (m_init[k]) begin
                chk(tag(k, "active_valid"), DW'(active_valid[k]), DW'(m_av[k]));
                chk(tag(k, "fill_full"), DW'(fill_full[k]), DW'(m_ff[k]));
                chk(tag(k, "bank_sel"), DW'(bank_sel[k]), DW'(m_sel[k]));
                chk(tag(k, "swap_pulse"), DW'(swap_pulse[k]), DW'(sw));
                chk(tag(k, "err_sticky"), DW'(err_sticky[k]), DW'(m_err[k]));
                chk(tag(k, "rd_valid"), DW'(rd_valid[k]), DW'(erv));
                for (int c = 0; c < N; c++) begin
                    if (erv[c] && e_rk[k][c]) begin
                        chk(tag(k, $sformatf("rd_dout%0d", c)),
                            rd_dout[k][c*DW +: DW], e_rd[k][c]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ld_addr[k] = '0; wb_addr[k] = '0; rd_addr[k] = '0;
            ld_din[k]  = '0; wb_din[k]  = '0;
        end
        idle();
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (2) step();
        chk("rst_bank_sel", DW'(bank_sel[0]), '0);
        chk("rst_active_valid", DW'(active_valid[0]), '0);
        chk("rst_err", DW'(err_sticky[0]), '0);
        chk("rst_rd_valid", DW'(rd_valid[0]), '0);

        // Load, commit, swap, read back on the ping-pong instance.
        idle(); set_ld(0, 0, 5, 72'hA5); step();
        idle(); fill_commit[0] = 1'b1; step();
        chk("t1_swap_pulse", DW'(swap_pulse[0]), DW'(1));
        chk("t1_bank_sel", DW'(bank_sel[0]), DW'(1));
        chk("t1_active_valid", DW'(active_valid[0]), DW'(1));
        idle(); step();
        chk("t1_swap_drop", DW'(swap_pulse[0]), '0);
        idle(); set_rd(0, 0, 5); step();
        chk("t1_rd_valid", DW'(rd_valid[0][0]), DW'(1));
        chk("t1_rd_dout", rd_dout[0][0 +: DW], 72'hA5);

        // Same-column load and write-back: write-back wins.
        idle(); set_ld(0, 1, 9, 72'h111); set_wb(0, 1, 9, 72'h222);
        #1;
        chk("t2_wb_ready", DW'(wb_ready[0][1]), DW'(1));
        chk("t2_ld_ready", DW'(ld_ready[0][1]), '0);
        step();
        idle(); set_ld(0, 1, 10, 72'h111);
        #1;
        chk("t2_ld_retry", DW'(ld_ready[0][1]), DW'(1));
        step();
        chk("t2_err", DW'(err_sticky[0]), '0);

        // ACTIVE -> FULL, dropped load, release swaps.
        idle(); fill_commit[0] = 1'b1; step();
        chk("t3_fill_full", DW'(fill_full[0]), DW'(1));
        idle(); set_ld(0, 2, 1, 72'h77);
        #1;
        chk("t3_ld_blocked", DW'(ld_ready[0]), '0);
        step();
        chk("t3_err_wr", DW'(err_sticky[0][0]), DW'(1));
        idle(); compute_release[0] = 1'b1; step();
        chk("t3_swap", DW'(swap_pulse[0]), DW'(1));
        chk("t3_bank_sel", DW'(bank_sel[0]), '0);
        chk("t3_fill_clr", DW'(fill_full[0]), '0);
        idle(); set_rd(0, 1, 9); step();
        chk("t3_wb_data", rd_dout[0][DW +: DW], 72'h222);
        idle(); set_rd(0, 1, 10); step();
        chk("t3_ld_data", rd_dout[0][DW +: DW], 72'h111);

        // Simultaneous commit and release in ACTIVE.
        idle(); fill_commit[0] = 1'b1; compute_release[0] = 1'b1; step();
        chk("t4_swap", DW'(swap_pulse[0]), DW'(1));
        chk("t4_bank_sel", DW'(bank_sel[0]), DW'(1));
        chk("t4_state", DW'({active_valid[0], fill_full[0]}), DW'(2'b10));
        idle(); step();
        chk("t4_one_pulse", DW'(swap_pulse[0]), '0);

        // Reset in the middle of a read; memory survives.
        idle(); set_rd(0, 0, 5); step();
        idle(); set_rd(0, 0, 5); rst_n[0] = 1'b0; step();
        chk("t5_rd_valid", DW'(rd_valid[0]), '0);
        chk("t5_flags", DW'({active_valid[0], fill_full[0], bank_sel[0],
                             swap_pulse[0], err_sticky[0]}), '0);
        idle(); fill_commit[0] = 1'b1; step();
        idle(); set_rd(0, 0, 5); step();
        chk("t5_kept_data", rd_dout[0][0 +: DW], 72'hA5);

        // Single-bank instance.
        idle(); set_rd(1, 0, 0); step();
        chk("sb_rd_err", DW'(err_sticky[1]), DW'(2'b10));
        chk("sb_rd_valid", DW'(rd_valid[1]), '0);
        idle(); set_ld(1, 2, 3, 72'h33); step();
        idle(); fill_commit[1] = 1'b1; step();
        chk("sb_active", DW'(active_valid[1]), DW'(1));
        chk("sb_bank_sel", DW'(bank_sel[1]), '0);
        chk("sb_swap", DW'(swap_pulse[1]), DW'(1));
        idle(); set_ld(1, 2, 4, 72'h44);
        #1;
        chk("sb_ld_blocked", DW'(ld_ready[1]), '0);
        step();
        idle(); set_rd(1, 2, 3); step();
        chk("sb_rd_data", rd_dout[1][2*DW +: DW], 72'h33);
        idle(); compute_release[1] = 1'b1; step();
        idle();
        #1;
        chk("sb_ld_open", DW'(ld_ready[1]), DW'(4'hF));
        step();
        idle(); set_ld(1, 0, 1, 72'h5); set_wb(1, 0, 1, 72'h6);
        #1;
        chk("sb_ld_prio", DW'(ld_ready[1][0]), DW'(1));
        chk("sb_wb_lose", DW'(wb_ready[1][0]), '0);
        step();

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            idle();
            for (int k = 0; k < 2; k++) begin
                rst_n[k] = ($urandom_range(0, 79) != 0);
                fill_commit[k]     = ($urandom_range(0, 5) == 0);
                compute_release[k] = ($urandom_range(0, 5) == 0);
                for (int c = 0; c < N; c++) begin
                    if (rst_n[k] && $urandom_range(0, 2) == 0)
                        set_ld(k, c, $urandom_range(0, DEPTH-1), rnd72());
                    if (rst_n[k] && $urandom_range(0, 3) == 0)
                        set_wb(k, c, $urandom_range(0, DEPTH-1), rnd72());
                    if ($urandom_range(0, 1) == 0)
                        set_rd(k, c, $urandom_range(0, DEPTH-1));
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fm_pingpong_buf_bank.md
Name: fm_pingpong_buf_bank

Overview:
Parametrised feature-map/guard buffer bank for the diff core. It gives every PE column a ping-pong pair of two-port memories. One bank (the fill bank) accepts external loads and PE write-back, while the other (the active bank) is read by the PE matrix. A bank-level controller swaps the banks via a commit/release handshake, which lets layer N+1 loading overlap layer N compute. With PINGPONG=0 the block collapses to a single shared bank.

Parameters:
N_COL, 4, number of PE columns (independent column memories)
DATA_W, 72, word width (9x8b fm or 12x6b guard)
DEPTH, 512, words per bank per column; AW = $clog2(DEPTH) derived
PINGPONG, 1, 1 = two banks per column; 0 = single bank, no overlap
WB_PRIO, 1, 1 = PE write-back beats load on the same column and cycle; 0 = load wins

Ports:
clk  in  1  core clock
rst_n  in  1  reset, synchronous, active-low
ld_addr  in  N_COL*AW  per-column load address (fill bank)
ld_din  in  N_COL*DATA_W  load data
ld_en  in  N_COL  load write request
ld_ready  out  N_COL  load accepted this cycle
wb_addr  in  N_COL*AW  PE write-back address (fill bank)
wb_din  in  N_COL*DATA_W  write-back data
wb_en  in  N_COL  write-back request
wb_ready  out  N_COL  write-back accepted this cycle
rd_addr  in  N_COL*AW  PE read address (active bank)
rd_en  in  N_COL  read request
rd_dout  out  N_COL*DATA_W  read data
rd_valid  out  N_COL  rd_dout valid
fill_commit  in  1  pulse: fill bank complete
compute_release  in  1  pulse: PE done with active bank
active_valid  out  1  active bank holds committed data
fill_full  out  1  committed fill bank waiting for swap
bank_sel  out  1  index of active bank (fill = ~bank_sel)
swap_pulse  out  1  one-cycle pulse on swap
err_sticky  out  2  [0] write dropped, [1] read of invalid bank

Behaviour:
- Reset (sync, rst_n=0 at posedge): bank_sel=0, active_valid=0, fill_full=0, swap_pulse=0, rd_valid=0, err_sticky=0. Memory contents are not cleared. Reset mid-operation drops in-flight reads (rd_valid=0 next cycle).
- Fill writability: fill_wr_ok = ~fill_full, and for PINGPONG=0 additionally ~active_valid.
- Per-column arbitration (combinational):
  - WB_PRIO=1: wb_ready=fill_wr_ok; ld_ready=fill_wr_ok & ~wb_en.
  - WB_PRIO=0: the same with ld and wb swapped.
  - The loser is not written and must hold its request.
- Write error: a request with fill_wr_ok=0 is dropped and sets err_sticky[0]. Losing arbitration is not an error.
- Write path: accepted write goes to bank ~bank_sel (PINGPONG=1) or bank 0.
- Read path: rd_en & active_valid reads bank bank_sel (bank 0 when PINGPONG=0). rd_dout/rd_valid follow after exactly 1 cycle. rd_en & ~active_valid sets err_sticky[1] and produces rd_valid=0.
- Controller FSM states are derived from {active_valid, fill_full}:
  - EMPTY (0,0): fill_commit -> swap; go to ACTIVE.
  - ACTIVE (1,0): compute_release -> EMPTY; fill_commit -> FULL; both in same cycle -> swap, stay ACTIVE.
  - FULL (1,1): compute_release -> swap, ACTIVE; fill_commit ignored.
  - (0,1) is unreachable.
- Swap actions: bank_sel toggles (PINGPONG=1 only), active_valid=1, fill_full=0, swap_pulse=1 for one cycle. The new state is visible the cycle after the triggering pulse.
- PINGPONG=0: bank_sel is constant 0. fill_commit in EMPTY sets active_valid=1 without toggling and still pulses swap_pulse. Writes are blocked while active_valid=1.
- Write and read to the same physical bank cannot occur when PINGPONG=1. With PINGPONG=0 they are excluded by the fill_wr_ok rule.

Optional Feature:
FMBUF_OCCUPANCY_EN
- With it: per column, the fill bank tracks max accepted write address + 1, as an AW+1-bit count.
- On swap the count is copied to a new output active_len (N_COL*(AW+1)) and the fill counter is cleared.
- A rd_en with rd_addr >= active_len[j] sets err_sticky[1] and produces rd_valid=0.
- Without it: no counters, no active_len port; reads are bounded only by active_valid.

Decomposition:
- Shared package (diff_demo_pkg): CONF_PE_COL, CONF_FM_BUF_DEPTH, CONF_GUARD_BUF_DEPTH as parameter defaults; enum bank_state_e {EMPTY, ACTIVE, FULL}.
- Sub-module: pingpong_bank_ctrl, holding the FSM, bank_sel and swap_pulse.
- Memories are existing two_port_mem instances, generate-looped per column per bank.

Test Plan:
- Reset, then ld col0 addr 5 = 0xA5, fill_commit -> swap_pulse once, bank_sel=1, active_valid=1. Then rd col0 addr 5 -> rd_valid 1 cycle later with 0xA5.
- ld and wb on the same column and cycle with WB_PRIO=1 -> wb_ready=1, ld_ready=0, mem holds wb data. Load retried next cycle succeeds; err_sticky stays 0.
- ACTIVE with fill_commit -> FULL, ld_ready=0. Then ld_en -> err_sticky[0]=1. Then compute_release -> swap, bank_sel toggles, fill_full=0.
- fill_commit and compute_release in the same ACTIVE cycle -> exactly one swap_pulse, state ACTIVE, bank_sel toggled.
- PINGPONG=0: commit -> active_valid=1, bank_sel stays 0, ld_ready=0. Release -> ld_ready=1. rd_en with active_valid=0 -> err_sticky[1]=1, rd_valid=0.
- rst_n low mid-read with rd_en asserted -> rd_valid=0 next cycle, all flags cleared. Data written before reset is still readable after the next commit.
